// File: rtl/jt93cx6_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jt93cx6_pkg
// Description : Shared opcodes, state encoding and helpers for the 93Cx6
//               serial EEPROM emulator.
// Revision    : 1.0 - initial release
// ============================================================================
package jt93cx6_pkg;

    // Main opcodes (two bits following the start bit)
    localparam logic [1:0] c_op_read  = 2'b10;
    localparam logic [1:0] c_op_write = 2'b01;
    localparam logic [1:0] c_op_erase = 2'b11;
    localparam logic [1:0] c_op_ext   = 2'b00;

    // Extended sub-codes carried in the top two address bits
    localparam logic [1:0] c_ext_ewen = 2'b11;
    localparam logic [1:0] c_ext_ewds = 2'b00;
    localparam logic [1:0] c_ext_eral = 2'b10;
    localparam logic [1:0] c_ext_wral = 2'b01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        READ    = 3'd2,
        DATA    = 3'd3,
        WAITCS  = 3'd4,
        WAITLOW = 3'd5,
        BUSY    = 3'd6
    } state_t;

    // Programming operation waiting for chip select to fall
    typedef enum logic [1:0] {
        PEND_WRITE = 2'd0,
        PEND_ERASE = 2'd1,
        PEND_ERAL  = 2'd2,
        PEND_WRAL  = 2'd3
    } pend_t;

    // Replace one byte of a 16-bit word (hi=1 selects the upper byte)
    function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                               input logic [7:0]  b,
                                               input logic        hi);
        return hi ? {b, word[7:0]} : {word[15:8], b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt93cx6_mem.sv
`default_nettype none
// ============================================================================
// Module      : jt93cx6_mem
// Description : 2**AW x 16 RAM, one write port, two registered read ports.
//               Port A feeds the serial engine, port B the host.
// Revision    : 1.0 - initial release
// ============================================================================
module jt93cx6_mem #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] addr_a,
    output logic [15:0]   dout_a,
    input  logic [AW-1:0] addr_b,
    output logic [15:0]   dout_b
);

    logic [15:0] r_mem [0:(2**AW)-1];

    // Single shared write port; contents are never reset
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    // Serial-side registered read
    always_ff @(posedge clk) begin
        dout_a <= r_mem[addr_a];
    end

    // Host-side registered read, output register cleared on reset
    always_ff @(posedge clk) begin
        if (rst) dout_b <= '0;
        else     dout_b <= r_mem[addr_b];
    end

endmodule
`default_nettype wire

// File: rtl/jt93cx6_eeprom.sv
`default_nettype none
// ============================================================================
// Module      : jt93cx6_eeprom
// Description : 93C46/56/66/76/86 serial EEPROM emulator with x8/x16
//               organisation, write protection, timed busy, sequential read
//               and a host port for NVRAM load/save with dirty tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module jt93cx6_eeprom
    import jt93cx6_pkg::*;
#(
    parameter int AW    = 6,
    parameter int TWR   = 32,
    parameter int SEQRD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          sdi,
    output logic          sdo,
    input  logic          scs,
    input  logic          org,
    input  logic [AW-1:0] h_addr,
    input  logic [15:0]   h_din,
    input  logic          h_we,
    output logic [15:0]   h_dout,
    output logic          h_busy,
    output logic          dirty,
    input  logic          dirty_clr
);

    localparam int c_words     = 2**AW;
    localparam int c_sweep_len = (TWR > c_words) ? TWR : c_words;
    localparam int c_cnt_w     = $clog2(c_sweep_len) + 1;

    state_t             r_state, w_next;
    pend_t              r_pend;
    logic               r_last_sclk, r_org, r_ewen, r_dirty;
    logic               r_rd_bit, r_rd_done;
    logic [AW+1:0]      r_sr;
    logic [4:0]         r_cnt;
    logic [AW:0]        r_addr;
    logic [15:0]        r_data;
    logic [c_cnt_w-1:0] r_bcnt, w_busy_last;

    logic               w_act, w_cmd_end, w_dat_end;
    logic               w_sweep, w_commit, w_ser_we, w_we;
    logic [AW+2:0]      w_full;
    logic [1:0]         w_op, w_ext;
    logic [AW:0]        w_cmd_addr, w_addr_inc;
    logic [4:0]         w_cmd_last, w_dat_last;
    logic [3:0]         w_bit_idx;
    logic [15:0]        w_din, w_rdata, w_rd_val, w_ser_data, w_wdata;
    logic [AW-1:0]      w_word_addr, w_ser_addr, w_waddr;

    // Serial decode helpers; LA-dependent fields are picked from a fixed-width
    // window because the shift register is cleared at every start bit
    assign w_act       = sclk & ~r_last_sclk & scs;
    assign w_full      = {r_sr, sdi};
    assign w_op        = r_org ? w_full[AW+1:AW]   : w_full[AW+2:AW+1];
    assign w_ext       = r_org ? w_full[AW-1:AW-2] : w_full[AW:AW-1];
    assign w_cmd_addr  = r_org ? {1'b0, w_full[AW-1:0]} : w_full[AW:0];
    assign w_cmd_last  = r_org ? 5'(AW + 1) : 5'(AW + 2);
    assign w_dat_last  = r_org ? 5'd15 : 5'd7;
    assign w_cmd_end   = w_act && (r_cnt == w_cmd_last);
    assign w_dat_end   = w_act && (r_cnt == w_dat_last);
    assign w_din       = {r_data[14:0], sdi};
    assign w_word_addr = r_org ? r_addr[AW-1:0] : r_addr[AW:1];
    assign w_addr_inc  = r_org ? {1'b0, r_addr[AW-1:0] + AW'(1)} : r_addr + (AW+1)'(1);
    assign w_rd_val    = r_org ? w_rdata
                               : {8'h00, (r_addr[0] ? w_rdata[15:8] : w_rdata[7:0])};
    assign w_bit_idx   = 4'(w_dat_last - r_cnt);

    // Programming: single-word ops commit in the first busy cycle, bulk ops
    // sweep one word per cycle from address zero
    assign w_sweep     = (r_pend == PEND_ERAL) || (r_pend == PEND_WRAL);
    assign w_busy_last = w_sweep ? c_cnt_w'(c_sweep_len - 1) : c_cnt_w'(TWR - 1);
    assign w_commit    = (r_state == BUSY) && (r_bcnt == '0);
    assign w_ser_we    = (r_state == BUSY) && (w_sweep ? (r_bcnt < c_cnt_w'(c_words)) : w_commit);
    assign w_ser_addr  = w_sweep ? r_bcnt[AW-1:0] : w_word_addr;

    // Write data for the pending op; x8 ops merge into the word read back
    always_comb begin
        w_ser_data = 16'hFFFF;
        case (r_pend)
            PEND_WRITE: w_ser_data = r_org ? r_data : merge_byte(w_rdata, r_data[7:0], r_addr[0]);
            PEND_ERASE: w_ser_data = r_org ? 16'hFFFF : merge_byte(w_rdata, 8'hFF, r_addr[0]);
            PEND_ERAL:  w_ser_data = 16'hFFFF;
            PEND_WRAL:  w_ser_data = r_org ? r_data : {r_data[7:0], r_data[7:0]};
            default:    w_ser_data = 16'hFFFF;
        endcase
    end

    // Serial commit always wins; host writes are blocked while busy anyway
    assign w_we    = w_ser_we | (h_we & ~h_busy);
    assign w_waddr = w_ser_we ? w_ser_addr : h_addr;
    assign w_wdata = w_ser_we ? w_ser_data : h_din;

    assign h_busy = (r_state == BUSY);
    assign sdo    = (r_state == READ) ? r_rd_bit : (r_state != BUSY);
    assign dirty  = r_dirty;

    jt93cx6_mem #(.AW(AW)) u_mem (
        .clk    (clk),
        .rst    (rst),
        .we     (w_we),
        .waddr  (w_waddr),
        .wdata  (w_wdata),
        .addr_a (w_word_addr),
        .dout_a (w_rdata),
        .addr_b (h_addr),
        .dout_b (h_dout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_act && sdi) w_next = CMD;
            CMD: begin
                if (!scs) w_next = IDLE;
                else if (w_cmd_end) begin
                    case (w_op)
                        c_op_read:  w_next = READ;
                        c_op_write: w_next = DATA;
                        c_op_erase: w_next = r_ewen ? WAITCS : WAITLOW;
                        default: begin
                            case (w_ext)
                                c_ext_eral: w_next = r_ewen ? WAITCS : WAITLOW;
                                c_ext_wral: w_next = DATA;
                                default:    w_next = WAITLOW;
                            endcase
                        end
                    endcase
                end
            end
            READ:    if (!scs) w_next = IDLE;
            DATA: begin
                if (!scs) w_next = IDLE;
                else if (w_dat_end) w_next = r_ewen ? WAITCS : WAITLOW;
            end
            WAITCS:  if (!scs) w_next = BUSY;
            WAITLOW: if (!scs) w_next = IDLE;
            BUSY:    if (r_bcnt == w_busy_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Serial datapath: shift registers, address, counters, protection, dirty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_sclk <= 1'b0;
            r_org       <= 1'b1;
            r_ewen      <= 1'b0;
            r_dirty     <= 1'b0;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_pend      <= PEND_WRITE;
            r_bcnt      <= '0;
            r_rd_bit    <= 1'b0;
            r_rd_done   <= 1'b0;
        end else begin
            r_last_sclk <= sclk;

            if (w_commit)       r_dirty <= 1'b1;
            else if (dirty_clr) r_dirty <= 1'b0;

            if (r_state == BUSY) r_bcnt <= r_bcnt + c_cnt_w'(1);
            else                 r_bcnt <= '0;

            case (r_state)
                IDLE: begin
                    if (w_act && sdi) begin
                        r_org <= org;
                        r_sr  <= '0;
                        r_cnt <= '0;
                    end
                end
                CMD: begin
                    if (w_act) begin
                        r_sr  <= w_full[AW+1:0];
                        r_cnt <= r_cnt + 5'd1;
                    end
                    if (w_cmd_end) begin
                        r_cnt     <= '0;
                        r_addr    <= w_cmd_addr;
                        r_data    <= '0;
                        r_rd_bit  <= 1'b0;
                        r_rd_done <= 1'b0;
                        case (w_op)
                            c_op_write: r_pend <= PEND_WRITE;
                            c_op_erase: r_pend <= PEND_ERASE;
                            c_op_ext: begin
                                case (w_ext)
                                    c_ext_ewen: r_ewen <= 1'b1;
                                    c_ext_ewds: r_ewen <= 1'b0;
                                    c_ext_eral: r_pend <= PEND_ERAL;
                                    default:    r_pend <= PEND_WRAL;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
                READ: begin
                    if (w_act) begin
                        r_rd_bit <= r_rd_done ? 1'b0 : w_rd_val[w_bit_idx];
                        if (!r_rd_done) begin
                            if (r_cnt == w_dat_last) begin
                                r_cnt <= '0;
                                if (SEQRD != 0) r_addr    <= w_addr_inc;
                                else            r_rd_done <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 5'd1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (w_act) begin
                        r_data <= w_din;
                        r_cnt  <= r_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jt93cx6_eeprom.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt93cx6_eeprom
// Description : Self-checking bench for jt93cx6_eeprom, comparing the serial
//               and host views against an array model of the EEPROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt93cx6_eeprom;

    localparam int AW  = 6;
    localparam int TWR = 32;
    localparam int NW  = 2**AW;

    logic          clk = 1'b0, rst = 1'b1;
    logic          sclk = 1'b0, sdi = 1'b0, scs = 1'b0, org = 1'b1;
    logic [AW-1:0] h_addr = '0;
    logic [15:0]   h_din = '0;
    logic          h_we = 1'b0, dirty_clr = 1'b0;
    logic          sdo, h_busy, dirty;
    logic [15:0]   h_dout;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [15:0]   model [0:NW-1];
    logic          model_ewen = 1'b0;

    always #5 clk = ~clk;

    jt93cx6_eeprom #(.AW(AW), .TWR(TWR), .SEQRD(1)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .sdi(sdi), .sdo(sdo), .scs(scs),
        .org(org), .h_addr(h_addr), .h_din(h_din), .h_we(h_we),
        .h_dout(h_dout), .h_busy(h_busy), .dirty(dirty), .dirty_clr(dirty_clr)
    );

    // ---------------- stimulus primitives ----------------
    task automatic sbit(input logic b, output logic o);
        @(negedge clk); sdi = b; sclk = 1'b0;
        @(negedge clk); sclk = 1'b1;
        @(negedge clk); o = sdo;
    endtask

    task automatic send(input logic [31:0] bits, input int n, output logic last_o);
        last_o = 1'b0;
        for (int i = n - 1; i >= 0; i--) sbit(bits[i], last_o);
    endtask

    task automatic cs_off();
        @(negedge clk); scs = 1'b0; sclk = 1'b0; sdi = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic cmd(input logic o16, input logic [1:0] op, input int a, output logic last_o);
        int la;
        logic [31:0] bits;
        la   = o16 ? AW : AW + 1;
        bits = (32'd1 << (2 + la)) | (32'(op) << la) | (32'(a) & ((32'd1 << la) - 32'd1));
        @(negedge clk); scs = 1'b1; org = o16;
        send(bits, 3 + la, last_o);
    endtask

    // Drop chip select and count cycles with sdo low / h_busy high.
    // With poke set, the host tries to overwrite word 0 while busy.
    task automatic measure(input bit poke, output int c_sdo, output int c_hb);
        @(negedge clk); scs = 1'b0; sclk = 1'b0; sdi = 1'b0;
        c_sdo = 0; c_hb = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (sdo === 1'b1 && h_busy === 1'b0) break;
            if (sdo !== 1'b1) c_sdo++;
            if (h_busy !== 1'b0) c_hb++;
            if (poke) begin h_addr = '0; h_din = 16'hDEAD; h_we = 1'b1; end
        end
        h_we = 1'b0;
    endtask

    task automatic ext(input logic [1:0] sub);
        logic o;
        cmd(1'b1, 2'b00, int'(sub) << (AW - 2), o);
        cs_off();
        if (sub == 2'b11) model_ewen = 1'b1;
        if (sub == 2'b00) model_ewen = 1'b0;
    endtask

    task automatic do_write(input logic o16, input int a, input logic [15:0] d, output int busy);
        logic o;
        int hb, w;
        cmd(o16, 2'b01, a, o);
        send(32'(d), o16 ? 16 : 8, o);
        measure(1'b0, busy, hb);
        if (model_ewen) begin
            if (o16) model[a] = d;
            else begin
                w = a >> 1;
                if (a % 2 == 1) model[w] = {d[7:0], model[w][7:0]};
                else            model[w] = {model[w][15:8], d[7:0]};
            end
        end
    endtask

    task automatic do_read(input logic o16, input int a, input int n,
                           output logic [31:0] val, output logic dummy);
        logic o;
        cmd(o16, 2'b10, a, dummy);
        val = '0;
        for (int i = 0; i < n; i++) begin
            sbit(1'b0, o);
            val = {val[30:0], o};
        end
        cs_off();
    endtask

    task automatic host_write(input int a, input logic [15:0] d);
        @(negedge clk); h_addr = AW'(a); h_din = d; h_we = 1'b1;
        @(negedge clk); h_we = 1'b0;
        model[a] = d;
    endtask

    task automatic host_read(input int a, output logic [15:0] d);
        @(negedge clk); h_addr = AW'(a);
        @(negedge clk); d = h_dout;
    endtask

    function automatic logic [15:0] model_byte(input int a);
        logic [15:0] w;
        w = model[a >> 1];
        return (a % 2 == 1) ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (sdo !== 1'b1)   begin n_fail++; $display("FAIL reset_sdo: got %b want 1", sdo); end
        n_checks++; if (h_busy !== 1'b0) begin n_fail++; $display("FAIL reset_h_busy: got %b want 0", h_busy); end
        n_checks++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL reset_dirty: got %b want 0", dirty); end
        n_checks++; if (h_dout !== 16'h0) begin n_fail++; $display("FAIL reset_h_dout: got %h want 0000", h_dout); end
        rst = 1'b0;
        for (int i = 0; i < NW; i++) host_write(i, 16'hFFFF);
        @(negedge clk);
        n_checks++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL host_no_dirty: got %b want 0", dirty); end
    endtask

    task automatic test_ewds_protect();
        int busy;
        logic [31:0] v;
        logic dm;
        ext(2'b00);
        do_write(1'b1, 5, 16'hA55A, busy);
        n_checks++; if (busy != 0) begin n_fail++; $display("FAIL ewds_busy: got %0d want 0", busy); end
        do_read(1'b1, 5, 16, v, dm);
        n_checks++; if (dm !== 1'b0) begin n_fail++; $display("FAIL ewds_dummy: got %b want 0", dm); end
        n_checks++; if (v !== 32'h0000FFFF) begin n_fail++; $display("FAIL ewds_read: got %h want FFFF", v); end
        n_checks++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL ewds_dirty: got %b want 0", dirty); end
    endtask

    task automatic test_write16();
        int busy;
        logic [31:0] v;
        logic dm;
        ext(2'b11);
        do_write(1'b1, 5, 16'hA55A, busy);
        n_checks++; if (busy != TWR) begin n_fail++; $display("FAIL w16_busy: got %0d want %0d", busy, TWR); end
        do_read(1'b1, 5, 16, v, dm);
        n_checks++; if (dm !== 1'b0) begin n_fail++; $display("FAIL w16_dummy: got %b want 0", dm); end
        n_checks++; if (v !== 32'h0000A55A) begin n_fail++; $display("FAIL w16_read: got %h want A55A", v); end
        n_checks++; if (dirty !== 1'b1) begin n_fail++; $display("FAIL w16_dirty: got %b want 1", dirty); end
    endtask

    task automatic test_write8();
        int busy;
        logic [31:0] v;
        logic [15:0] d;
        logic dm;
        do_write(1'b0, 11, 16'h003C, busy);
        n_checks++; if (busy != TWR) begin n_fail++; $display("FAIL w8_busy: got %0d want %0d", busy, TWR); end
        host_read(5, d);
        n_checks++; if (d !== 16'h3C5A) begin n_fail++; $display("FAIL w8_word: got %h want 3C5A", d); end
        do_read(1'b0, 10, 8, v, dm);
        n_checks++; if (v !== 32'h5A) begin n_fail++; $display("FAIL r8_low: got %h want 5A", v); end
    endtask

    task automatic test_seq_read();
        logic [31:0] v;
        logic dm;
        host_write(NW - 1, 16'($urandom));
        host_write(0, 16'($urandom));
        do_read(1'b1, NW - 1, 32, v, dm);
        n_checks++;
        if (v !== {model[NW-1], model[0]}) begin
            n_fail++; $display("FAIL seq_wrap: got %h want %h", v, {model[NW-1], model[0]});
        end
    endtask

    task automatic test_dirty_clr();
        logic o;
        @(negedge clk); dirty_clr = 1'b1;
        @(negedge clk); dirty_clr = 1'b0;
        n_checks++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL dirty_clr: got %b want 0", dirty); end
        cmd(1'b1, 2'b01, 9, o);
        send(32'h0000_1357, 16, o);
        @(negedge clk); scs = 1'b0; sclk = 1'b0;
        @(negedge clk); dirty_clr = 1'b1;
        @(negedge clk); dirty_clr = 1'b0;
        model[9] = 16'h1357;
        n_checks++; if (dirty !== 1'b1) begin n_fail++; $display("FAIL dirty_clr_vs_commit: got %b want 1", dirty); end
        for (int k = 0; k < 200 && sdo !== 1'b1; k++) @(negedge clk);
        n_checks++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL dirty_ready: got %b want 1", sdo); end
    endtask

    task automatic test_bulk();
        logic o;
        logic [15:0] d;
        int cs, ch, bad;
        cmd(1'b1, 2'b00, 1 << (AW - 2), o);
        send(32'h0000_1234, 16, o);
        measure(1'b1, cs, ch);
        for (int i = 0; i < NW; i++) model[i] = 16'h1234;
        n_checks++; if (ch != NW) begin n_fail++; $display("FAIL wral_h_busy: got %0d want %0d", ch, NW); end
        n_checks++; if (cs != NW) begin n_fail++; $display("FAIL wral_sdo_busy: got %0d want %0d", cs, NW); end
        bad = 0;
        for (int i = 0; i < NW; i++) begin
            host_read(i, d);
            n_checks++;
            if (d !== 16'h1234) begin n_fail++; bad++; if (bad < 4) $display("FAIL wral_word%0d: got %h want 1234", i, d); end
        end
        cmd(1'b1, 2'b00, 2 << (AW - 2), o);
        measure(1'b0, cs, ch);
        for (int i = 0; i < NW; i++) model[i] = 16'hFFFF;
        n_checks++; if (cs != NW) begin n_fail++; $display("FAIL eral_busy: got %0d want %0d", cs, NW); end
        bad = 0;
        for (int i = 0; i < NW; i++) begin
            host_read(i, d);
            n_checks++;
            if (d !== 16'hFFFF) begin n_fail++; bad++; if (bad < 4) $display("FAIL eral_word%0d: got %h want FFFF", i, d); end
        end
    endtask

    task automatic test_abort();
        logic o, dm;
        logic [31:0] v;
        logic [15:0] d;
        host_write(5, 16'h6B2D);
        @(negedge clk); scs = 1'b1; org = 1'b1;
        send(32'b1_01_000, 6, o);
        cs_off();
        repeat (TWR + 4) @(negedge clk);
        n_checks++; if (h_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", h_busy); end
        do_read(1'b1, 5, 16, v, dm);
        n_checks++; if (dm !== 1'b0) begin n_fail++; $display("FAIL abort_dummy: got %b want 0", dm); end
        n_checks++; if (v !== 32'h6B2D) begin n_fail++; $display("FAIL abort_read: got %h want 6B2D", v); end
        host_read(5, d);
        n_checks++; if (d !== 16'h6B2D) begin n_fail++; $display("FAIL abort_mem: got %h want 6B2D", d); end
    endtask

    task automatic test_random();
        int kind, a, busy;
        logic [15:0] d;
        logic [31:0] v;
        logic dm;
        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 3));
            d    = 16'($urandom);
            case (kind)
                0: begin
                    a = int'($urandom_range(0, NW - 1));
                    do_write(1'b1, a, d, busy);
                    n_checks++; if (busy != TWR) begin n_fail++; $display("FAIL rnd_w16_busy: got %0d want %0d", busy, TWR); end
                end
                1: begin
                    a = int'($urandom_range(0, 2 * NW - 1));
                    do_write(1'b0, a, d, busy);
                    n_checks++; if (busy != TWR) begin n_fail++; $display("FAIL rnd_w8_busy: got %0d want %0d", busy, TWR); end
                end
                2: begin
                    a = int'($urandom_range(0, NW - 1));
                    do_read(1'b1, a, 16, v, dm);
                    n_checks++; if (v !== 32'(model[a])) begin n_fail++; $display("FAIL rnd_r16 @%0d: got %h want %h", a, v, model[a]); end
                end
                default: begin
                    a = int'($urandom_range(0, 2 * NW - 1));
                    do_read(1'b0, a, 8, v, dm);
                    n_checks++; if (v !== 32'(model_byte(a))) begin n_fail++; $display("FAIL rnd_r8 @%0d: got %h want %h", a, v, model_byte(a)); end
                end
            endcase
        end
    endtask

    task automatic test_reset_busy();
        logic o;
        logic [15:0] d;
        int busy;
        host_write(NW - 1, 16'h5A5A);
        cmd(1'b1, 2'b00, 1 << (AW - 2), o);
        send(32'h0000_00AA, 16, o);
        @(negedge clk); scs = 1'b0; sclk = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (h_busy !== 1'b0) begin n_fail++; $display("FAIL rstbusy_h_busy: got %b want 0", h_busy); end
        n_checks++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL rstbusy_sdo: got %b want 1", sdo); end
        rst = 1'b0;
        model_ewen = 1'b0;
        host_read(0, d);
        n_checks++; if (d !== 16'h00AA) begin n_fail++; $display("FAIL rstbusy_word0: got %h want 00AA", d); end
        host_read(NW - 1, d);
        n_checks++; if (d !== 16'h5A5A) begin n_fail++; $display("FAIL rstbusy_last: got %h want 5A5A", d); end
        host_write(7, 16'h7777);
        do_write(1'b1, 7, 16'h1111, busy);
        n_checks++; if (busy != 0) begin n_fail++; $display("FAIL rst_ewen_busy: got %0d want 0", busy); end
        host_read(7, d);
        n_checks++; if (d !== 16'h7777) begin n_fail++; $display("FAIL rst_ewen_mem: got %h want 7777", d); end
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ewds_protect();
        test_write16();
        test_write8();
        test_seq_read();
        test_dirty_clr();
        test_bulk();
        test_abort();
        test_random();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
